// File: rtl/led_pkg.sv
// Shared types, constants and the brightness-scaling helper for the
// WS2812 frame path.
package led_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_LATCH = 2'd2
    } seq_state_t;

    localparam int CLK_HZ          = 48_000_000;
    localparam int WS_RESET_CYCLES = 14400;
    localparam int PIXEL_W         = 24;

    // (c * (b + 1)) >> 8: b=255 is identity, result truncated
    function automatic logic [7:0] scale_ch(
        input logic [7:0] c,
        input logic [7:0] b
    );
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return p[15:8];
    endfunction

    function automatic logic [PIXEL_W-1:0] scale_px(
        input logic [PIXEL_W-1:0] px,
        input logic [7:0]         b
    );
        return {scale_ch(px[23:16], b),
                scale_ch(px[15:8],  b),
                scale_ch(px[7:0],   b)};
    endfunction

endpackage

// File: rtl/led_frame_sequencer_pixel_ram.sv
// Pixel buffer: one synchronous write port, one asynchronous read port.
// A read colliding with a write on the same edge returns the old word.
module pixel_ram
    import led_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [PIXEL_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [PIXEL_W-1:0] o_rdata
);

    logic [PIXEL_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we && (int'(i_waddr) < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame source for led_driver: streams the scaled pixel buffer one word
// per done pulse, then holds the WS2812 latch gap and flags completion.
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int  NUM_PIXELS   = 8,
    parameter int  RESET_CYCLES = WS_RESET_CYCLES,
    localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic [7:0]         brightness,
    input  logic               start,
    input  logic               done,
    output logic [PIXEL_W-1:0] rgb,
    output logic               load,
    output logic               busy,
    output logic               frame_done
);

    localparam int CW = $clog2(RESET_CYCLES + 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_PIXELS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RESET_CYCLES - 1);

    seq_state_t r_state;
    seq_state_t w_state_nxt;

    logic [AW-1:0]      r_idx;
    logic [PIXEL_W-1:0] r_rgb;
    logic               r_load;
    logic               r_busy;
    logic               r_fdone;
    logic               r_pending;
    logic [CW-1:0]      r_cnt;
    logic [7:0]         r_bright;

    logic               w_go;
    logic               w_adv;
    logic               w_end;
    logic [AW-1:0]      w_raddr;
    logic [PIXEL_W-1:0] w_rdata;

    pixel_ram #(
        .DEPTH (NUM_PIXELS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (wr_en),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_adv       = 1'b0;
        w_end       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_go        = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (done) begin
                    if (r_idx == IDX_LAST) begin
                        w_end       = 1'b1;
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            S_LATCH: begin
                // leave one cycle after the frame_done pulse
                if (r_fdone) begin
                    if (r_pending || start) begin
                        w_go        = 1'b1;
                        w_state_nxt = S_SEND;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_raddr = w_adv ? (r_idx + AW'(1)) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx     <= '0;
            r_rgb     <= '0;
            r_load    <= 1'b0;
            r_busy    <= 1'b0;
            r_fdone   <= 1'b0;
            r_pending <= 1'b0;
            r_cnt     <= '0;
            r_bright  <= 8'hFF;
        end else begin
            r_fdone <= (r_state == S_LATCH) && (r_cnt == CNT_LAST);

            if (w_end) begin
                r_cnt <= '0;
            end else if (r_state == S_LATCH) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_go) begin
                r_pending <= 1'b0;
            end else if (start && r_busy) begin
                r_pending <= 1'b1;
            end

            if (w_go) begin
                r_bright <= brightness;
                r_idx    <= '0;
                r_rgb    <= scale_px(w_rdata, brightness);
                r_load   <= 1'b1;
                r_busy   <= 1'b1;
            end else if (w_adv) begin
                r_idx <= r_idx + AW'(1);
                r_rgb <= scale_px(w_rdata, r_bright);
            end else if (w_end) begin
                r_load <= 1'b0;
            end else if (r_state == S_IDLE) begin
                r_rgb <= scale_px(w_rdata, r_bright);
            end

            if ((r_state == S_LATCH) && (w_state_nxt == S_IDLE)) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        rgb        = r_rgb;
        load       = r_load;
        busy       = r_busy;
        frame_done = r_fdone;
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed and randomized frames against a per-pixel reference of the
// buffer, brightness scaling and latch-gap timing.
module tb_led_frame_sequencer;

    localparam int NP = 3;
    localparam int RC = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic [7:0]  brightness = '0;
    logic        start = 1'b0;
    logic        done = 1'b0;
    logic [23:0] rgb;
    logic        load;
    logic        busy;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    logic [23:0] ref_mem [NP];

    led_frame_sequencer #(
        .NUM_PIXELS   (NP),
        .RESET_CYCLES (RC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .brightness (brightness),
        .start      (start),
        .done       (done),
        .rgb        (rgb),
        .load       (load),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ref_scale(input logic [23:0] px,
                                              input logic [7:0] b);
        int c;
        logic [23:0] r;
        r = '0;
        for (int j = 0; j < 3; j++) begin
            c = int'((px >> (8 * j)) & 24'hFF);
            c = (c * (int'(b) + 1)) / 256;
            r = r | (24'(c) << (8 * j));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick;
        wr_en = 1'b0;
        if (int'(a) < NP) ref_mem[a] = d;
    endtask

    task automatic wait_fd(input string tag);
        int k;
        k = 0;
        do begin
            tick;
            k++;
        end while (!frame_done && k <= 2 * RC);
        chk(tag, k, RC);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit kick,
                              input bit chained, input logic [7:0] nb);
        logic [23:0] cur;
        int w;
        int lo;
        if (!chained) begin
            brightness = b;
            start = 1'b1;
            tick;
            start = 1'b0;
        end
        brightness = nb;
        cur = ref_scale(ref_mem[0], b);
        chk("start_load", load, 1);
        chk("start_busy", busy, 1);
        chk("px0", rgb, cur);
        for (int i = 0; i < NP; i++) begin
            lo = (kick && i == 0) ? 1 : 0;
            w = $urandom_range(3, lo);
            for (int j = 0; j < w; j++) begin
                if (kick && i == 0 && j == 0) start = 1'b1;
                tick;
                start = 1'b0;
                chk("hold", rgb, cur);
                chk("hold_load", load, 1);
            end
            done = 1'b1;
            tick;
            done = 1'b0;
            if (i < NP - 1) begin
                cur = ref_scale(ref_mem[i+1], b);
                chk("pxn", rgb, cur);
                chk("load_mid", load, 1);
            end else begin
                chk("load_fall", load, 0);
                chk("rgb_keep", rgb, cur);
                chk("busy_latch", busy, 1);
            end
        end
        wait_fd("fd_gap");
        chk("fd_busy", busy, 1);
        tick;
        chk("fd_pulse", frame_done, 0);
        if (!kick) begin
            chk("idle_busy", busy, 0);
            chk("idle_load", load, 0);
        end
    endtask

    initial begin
        logic fd_seen;
        logic [7:0] rb;

        #1 rst = 1'b0;
        #1;
        chk("rst_rgb", rgb, 0);
        chk("rst_load", load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        tick;
        tick;
        rst = 1'b1;
        tick;

        wr(2'd0, 24'hFF0000);
        wr(2'd1, 24'h00FF00);
        wr(2'd2, 24'h0000FF);
        tick;
        chk("idle_track", rgb, 24'hFF0000);
        send_frame(8'd255, 1'b0, 1'b0, 8'd255);

        wr(2'd0, 24'hFF8040);
        send_frame(8'd127, 1'b0, 1'b0, 8'd127);
        tick;
        chk("b127", rgb, 24'h7F4020);
        send_frame(8'd0, 1'b0, 1'b0, 8'd0);
        tick;
        chk("b0", rgb, 24'h000000);

        done = 1'b1;
        tick;
        done = 1'b0;
        chk("spur_busy", busy, 0);
        chk("spur_load", load, 0);
        tick;
        chk("spur_fd", frame_done, 0);

        wr(2'd3, 24'hDEADBE);
        send_frame(8'd255, 1'b0, 1'b0, 8'd255);

        send_frame(8'd200, 1'b1, 1'b0, 8'd77);
        send_frame(8'd77, 1'b0, 1'b1, 8'd77);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("no_third", load, 0);
        end

        wr(2'd0, 24'h111111);
        wr(2'd1, 24'h222222);
        wr(2'd2, 24'h333333);
        brightness = 8'd255;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("wr_px0", rgb, 24'h111111);
        wr_en = 1'b1;
        wr_addr = 2'd2;
        wr_data = 24'h123456;
        tick;
        wr_en = 1'b0;
        ref_mem[2] = 24'h123456;
        chk("wr_hold", rgb, 24'h111111);
        done = 1'b1;
        wr_en = 1'b1;
        wr_addr = 2'd1;
        wr_data = 24'hABCDEF;
        tick;
        done = 1'b0;
        wr_en = 1'b0;
        ref_mem[1] = 24'hABCDEF;
        chk("rbw", rgb, 24'h222222);
        done = 1'b1;
        tick;
        done = 1'b0;
        chk("late_wr", rgb, 24'h123456);
        done = 1'b1;
        tick;
        done = 1'b0;
        chk("wr_load", load, 0);
        wait_fd("fd_wr");
        tick;
        chk("wr_idle", busy, 0);
        send_frame(8'd255, 1'b0, 1'b0, 8'd255);

        brightness = 8'd255;
        start = 1'b1;
        tick;
        start = 1'b0;
        done = 1'b1;
        tick;
        done = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("arst_rgb", rgb, 0);
        chk("arst_load", load, 0);
        chk("arst_busy", busy, 0);
        tick;
        tick;
        rst = 1'b1;
        fd_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (frame_done) fd_seen = 1'b1;
        end
        chk("arst_nofd", fd_seen, 0);
        send_frame(8'd99, 1'b0, 1'b0, 8'd99);

        for (int n = 0; n < 4; n++) begin
            for (int p = 0; p < NP; p++) begin
                wr(2'(p), 24'($urandom));
            end
            rb = 8'($urandom);
            send_frame(rb, 1'b0, 1'b0, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
